sram_responder: RTL and testbench

- Memory-side responder for the Z80 bank mapper's RAM request interface.
- Accepts level-held read/write strobes, a 19-bit physical address and write data from the mapper.
- Drives an external asynchronous 512Kx8 SRAM with programmable wait states.
- Returns read data plus a `ready` handshake; the mapper turns this into the CPU WAIT line.

---
 rtl/sram_responder_if.sv | 22 ++
 rtl/sram_responder.sv | 130 +++++++++++++
 tb/tb_sram_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// Mapper-side request bus for the SRAM responder.
// Level-held read/write strobes, address, data and ready handshake.
interface sram_responder_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] addr;
  logic              rd_req;
  logic              we_req;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ready;

  modport master (
    output addr, rd_req, we_req, wdata,
    input  rdata, ready
  );

  modport slave (
    input  addr, rd_req, we_req, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/sram_responder.sv
// Async 512Kx8 SRAM responder for the Z80 bank mapper.
// Registered strobes, programmable wait states and turnaround.
module sram_responder #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_STATES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  sram_responder_if.slave   bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, DONE, TURN
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [1:0] TC = 2'(TURN_CYCLES - 1);

  state_t            state, nxt;
  logic              op_wr, op_wr_d;
  logic [3:0]        wcnt, wcnt_d;
  logic [1:0]        tcnt, tcnt_d;
  logic              ready_q, ready_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        dq_out_d;
  logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic              req_any, req_live, busy;

  assign req_any  = bus.rd_req | bus.we_req;
  assign req_live = op_wr ? bus.we_req : bus.rd_req;

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  // State, counters and every output are registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_wr       <= 1'b0;
      wcnt        <= '0;
      tcnt        <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= nxt;
      op_wr       <= op_wr_d;
      wcnt        <= wcnt_d;
      tcnt        <= tcnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
    end
  end

  // Next state: DONE is left only once the handshake is over,
  // so a held request can never start a second access
  always_comb begin
    nxt     = state;
    op_wr_d = op_wr;
    wcnt_d  = wcnt;
    tcnt_d  = tcnt;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          nxt     = SETUP;
          op_wr_d = bus.we_req;
        end
      end
      SETUP: begin
        nxt    = ACCESS;
        wcnt_d = WS;
      end
      ACCESS: begin
        if (wcnt == 4'd0) nxt = DONE;
        else wcnt_d = wcnt - 4'd1;
      end
      DONE: begin
        if (!ready_q || !req_live) begin
          nxt    = TURN;
          tcnt_d = TC;
        end
      end
      TURN: begin
        if (tcnt == 2'd0) nxt = IDLE;
        else tcnt_d = tcnt - 2'd1;
      end
      default: nxt = IDLE;
    endcase
  end

  // Output values for the state being entered on this edge
  always_comb begin
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    rdata_d  = rdata_q;
    if (state == IDLE && req_any) begin
      addr_d   = bus.addr;
      dq_out_d = bus.wdata;
    end
    if (state == ACCESS && wcnt == 4'd0 && !op_wr)
      rdata_d = sram_dq_in;
    busy    = (nxt == SETUP) || (nxt == ACCESS) || (nxt == DONE);
    ce_n_d  = !busy;
    oe_n_d  = !(!op_wr_d && ((nxt == SETUP) || (nxt == ACCESS)));
    we_n_d  = !(op_wr_d && (nxt == ACCESS));
    dq_oe_d = op_wr_d && busy;
    ready_d = (nxt == DONE) && req_live;
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a read-data scoreboard.
// Requests are driven 1 time unit after an edge (edge 0).
module tb_sram_responder;

  logic clk;
  logic reset;

  sram_responder_if #(.ADDR_W(19)) bus0 ();
  sram_responder_if #(.ADDR_W(19)) bus1 ();

  logic [1:0]  ce_n, oe_n, we_n, dq_oe, rdy;
  logic [18:0] saddr  [2];
  logic [7:0]  dq_out [2];
  logic [7:0]  dq_in  [2];
  logic [7:0]  rdat   [2];
  logic [7:0]  mem_a  [0:524287];

  assign rdy     = {bus1.ready, bus0.ready};
  assign rdat[0] = bus0.rdata;
  assign rdat[1] = bus1.rdata;

  sram_responder #(
    .ADDR_W(19), .WAIT_STATES(2), .TURN_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus0.slave),
    .sram_addr(saddr[0]), .sram_dq_out(dq_out[0]),
    .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
    .sram_we_n(we_n[0])
  );

  sram_responder #(
    .ADDR_W(19), .WAIT_STATES(0), .TURN_CYCLES(1)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .sram_addr(saddr[1]), .sram_dq_out(dq_out[1]),
    .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
    .sram_we_n(we_n[1])
  );

  // SRAM model for dut: array, written while ce_n and we_n are low
  always @(posedge clk)
    if (!ce_n[0] && !we_n[0]) mem_a[saddr[0]] <= dq_out[0];

  assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem_a[saddr[0]] : 8'h00;
  // SRAM model for dut0: data is a fixed function of address
  assign dq_in[1] = saddr[1][7:0] ^ 8'h58;

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;
  logic [7:0] sb [$];

  int we_low, oe_low, dq_hi, rdy_cnt, first_rdy, rdy_drop;
  int ce_rise, ce_fall, overlap, bad_bus;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic rd,
                         input logic wr, input logic [18:0] a,
                         input logic [7:0] d);
    if (sel == 0) begin
      bus0.addr = a; bus0.wdata = d;
      bus0.rd_req = rd; bus0.we_req = wr;
    end else begin
      bus1.addr = a; bus1.wdata = d;
      bus1.rd_req = rd; bus1.we_req = wr;
    end
  endtask

  task automatic drop_req(input int sel);
    if (sel == 0) begin
      bus0.rd_req = 1'b0; bus0.we_req = 1'b0;
    end else begin
      bus1.rd_req = 1'b0; bus1.we_req = 1'b0;
    end
  endtask

  // Issue one access after edge 0, observe edges 1..n
  task automatic access(input int sel, input logic rd,
                        input logic wr, input logic [18:0] a,
                        input logic [7:0] d, input int drop_at,
                        input int n);
    logic prev_rdy, prev_ce;
    we_low = 0; oe_low = 0; dq_hi = 0; rdy_cnt = 0;
    first_rdy = -1; rdy_drop = -1; ce_rise = -1; ce_fall = 0;
    overlap = 0; bad_bus = 0;
    prev_rdy = rdy[sel];
    prev_ce  = ce_n[sel];
    set_req(sel, rd, wr, a, d);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      if (!we_n[sel]) we_low++;
      if (!oe_n[sel]) oe_low++;
      if (dq_oe[sel]) dq_hi++;
      if (rdy[sel]) rdy_cnt++;
      if (!we_n[sel] && !oe_n[sel]) overlap++;
      if (!ce_n[sel] && (saddr[sel] !== a ||
          (wr && dq_out[sel] !== d))) bad_bus++;
      if (rdy[sel] && !prev_rdy) begin
        if (first_rdy < 0) first_rdy = e;
        if (sb.size() == 0)
          chk("sb_spurious_ready", 32'(rdy[sel]), 32'd0);
        else
          chk("sb_rdata", 32'(rdat[sel]), 32'(sb.pop_front()));
      end
      if (!rdy[sel] && prev_rdy && rdy_drop < 0) rdy_drop = e;
      if (ce_n[sel] && !prev_ce && ce_rise < 0) ce_rise = e;
      if (!ce_n[sel] && prev_ce) ce_fall++;
      prev_rdy = rdy[sel];
      prev_ce  = ce_n[sel];
      if (e == drop_at) drop_req(sel);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 19'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 19'h0, 8'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) @(posedge clk);
    #1;
    chk("rst_ce_n", 32'(ce_n[0]), 32'd1);
    chk("rst_oe_n", 32'(oe_n[0]), 32'd1);
    chk("rst_we_n", 32'(we_n[0]), 32'd1);
    chk("rst_dq_oe", 32'(dq_oe[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_addr", 32'(saddr[0]), 32'd0);
    chk("rst_rdata", 32'(rdat[0]), 32'd0);

    // Write 0xC3 to 0x2A5F3, held until ready, dropped after edge 7
    sb.push_back(8'h00);
    access(0, 1'b0, 1'b1, 19'h2A5F3, 8'hC3, 7, 10);
    chk("wr_we_low", 32'(we_low), 32'd3);
    chk("wr_oe_low", 32'(oe_low), 32'd0);
    chk("wr_first_rdy", 32'(first_rdy), 32'd5);
    chk("wr_rdy_drop", 32'(rdy_drop), 32'd8);
    chk("wr_ce_rise", 32'(ce_rise), 32'd8);
    chk("wr_dq_hi", 32'(dq_hi), 32'd7);
    chk("wr_bus_stable", 32'(bad_bus), 32'd0);
    chk("wr_mem", 32'(mem_a[19'h2A5F3]), 32'hC3);

    // Read it back, holding rd_req 20 cycles
    sb.push_back(8'hC3);
    access(0, 1'b1, 1'b0, 19'h2A5F3, 8'h00, 20, 23);
    chk("rd_oe_low", 32'(oe_low), 32'd4);
    chk("rd_first_rdy", 32'(first_rdy), 32'd5);
    chk("rd_rdy_cnt", 32'(rdy_cnt), 32'd16);
    chk("rd_rdy_drop", 32'(rdy_drop), 32'd21);
    chk("rd_single", 32'(ce_fall), 32'd1);
    chk("rd_dq_oe", 32'(dq_hi), 32'd0);
    chk("rd_overlap", 32'(overlap), 32'd0);
    chk("rd_rdata_hold", 32'(rdat[0]), 32'hC3);

    // Read and write together: write wins
    sb.push_back(8'hC3);
    access(0, 1'b1, 1'b1, 19'h00100, 8'h55, 7, 10);
    chk("both_oe_low", 32'(oe_low), 32'd0);
    chk("both_we_low", 32'(we_low), 32'd3);
    chk("both_first_rdy", 32'(first_rdy), 32'd5);
    chk("both_mem", 32'(mem_a[19'h00100]), 32'h55);
    chk("both_rdata", 32'(rdat[0]), 32'hC3);

    // Write aborted one cycle after SETUP still gets a full pulse
    access(0, 1'b0, 1'b1, 19'h00200, 8'h3C, 2, 8);
    chk("abort_we_low", 32'(we_low), 32'd3);
    chk("abort_rdy_cnt", 32'(rdy_cnt), 32'd0);
    chk("abort_ce_rise", 32'(ce_rise), 32'd6);
    chk("abort_mem", 32'(mem_a[19'h00200]), 32'h3C);

    // Back in IDLE: a fresh read completes on time
    sb.push_back(8'h3C);
    access(0, 1'b1, 1'b0, 19'h00200, 8'h00, 6, 9);
    chk("post_abort_rdy", 32'(first_rdy), 32'd5);
    chk("post_abort_oe", 32'(oe_low), 32'd4);

    // Reset pulsed in the middle of a write strobe
    set_req(0, 1'b0, 1'b1, 19'h00300, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_we_n", 32'(we_n[0]), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_we_n", 32'(we_n[0]), 32'd1);
    chk("mid_rst_ce_n", 32'(ce_n[0]), 32'd1);
    chk("mid_rst_dq_oe", 32'(dq_oe[0]), 32'd0);
    chk("mid_rst_rdata", 32'(rdat[0]), 32'd0);
    drop_req(0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Normal read after reset release
    sb.push_back(8'h55);
    access(0, 1'b1, 1'b0, 19'h00100, 8'h00, 6, 9);
    chk("post_rst_rdy", 32'(first_rdy), 32'd5);

    // Zero wait states: read at top of memory
    sb.push_back(8'hA7);
    access(1, 1'b1, 1'b0, 19'h7FFFF, 8'h00, 4, 7);
    chk("ws0_first_rdy", 32'(first_rdy), 32'd3);
    chk("ws0_oe_low", 32'(oe_low), 32'd2);
    chk("ws0_rdy_drop", 32'(rdy_drop), 32'd5);
    chk("ws0_addr", 32'(saddr[1]), 32'h7FFFF);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
